br_resolve_queue: RTL and testbench
===================================

Name: br_resolve_queue

Overview:
- Commit-side partner of the fetch BTB.
- Fetch pushes each predicted control-flow instruction (pc, predicted next pc, predicted-taken) into an in-order queue.
- At ROB commit, the head entry is compared with the architectural outcome. The block then drives the BTB training interface (commit pc, target, taken, opcode) and, on mismatch, a registered mispredict/redirect with a full queue flush.
- Sits between the fetch stage, the ROB commit port and the BTB.

Parameters:
- QUEUE_DEPTH, 3, log2 of queue entries (8 entries).
- RESET_PC, 32'h1eceb000, redirect_pc value held during and after reset.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset (low = in reset)
- enq_valid  input  1  fetch pushes a prediction record
- enq_ready  output  1  queue not full and no flush pending
- enq_pc  input  32  pc of fetched control instruction
- enq_pred_next  input  32  pc fetch used next
- enq_pred_take  input  1  fetch predicted taken
- rob_commit  input  1  ROB retires an instruction this cycle
- commit_pc  input  32  pc of retiring instruction
- commit_pc_next  input  32  architectural next pc
- commit_opcode  input  7  opcode of retiring instruction
- upd_valid  output  1  BTB training strobe (registered)
- upd_take  output  1  actual taken
- upd_pc  output  32  pc to train
- upd_target  output  32  actual next pc
- upd_opcode  output  7  opcode to train
- mispredict  output  1  one-cycle flush/redirect pulse (registered)
- redirect_pc  output  32  correct fetch pc when mispredict=1
- q_count  output  QUEUE_DEPTH+1  current occupancy
- br_commits  output  32  committed control instructions (wraps)
- br_mispredicts  output  32  mispredicts (wraps)

Behaviour:
- Reset (rst low, async): queue empty (head=tail=0, count=0); all outputs 0 except redirect_pc=RESET_PC and enq_ready=0 while in reset.
- Control opcodes: op_b_br, op_b_jal, op_b_jalr only. A commit of any other opcode has no effect.
- Circular buffer of 2**QUEUE_DEPTH entries. Pointers are QUEUE_DEPTH+1 bits so full and empty are distinguishable; wrap-around is natural.
- enq_ready = !full && !mispredict. An enqueue occurs when enq_valid && enq_ready.
- Control commit (rob_commit && control opcode), evaluated combinationally against the head:
  - actual_take = (opcode==op_b_br) ? (commit_pc_next != commit_pc+4) : 1. All 32-bit arithmetic wraps.
  - Match when queue non-empty, head.pc == commit_pc, head.pred_next == commit_pc_next, and head.pred_take == actual_take.
  - Empty queue or head.pc != commit_pc is a mispredict; the prediction is treated as pc+4, not taken.
- On match: pop head. Next cycle upd_valid=1 with actual values.
- On mispredict:
  - Queue cleared at the clock edge; any same-cycle enqueue is dropped.
  - Next cycle: mispredict=1, redirect_pc=commit_pc_next, upd_valid=1.
  - During the mispredict=1 cycle enq_ready=0, so wrong-path pushes are dropped. The queue accepts again the following cycle.
- Simultaneous enqueue and matching pop: both take effect; count unchanged. Enqueue into a full queue is allowed only when a matching pop happens the same cycle; enq_ready stays low when full (conservative).
- Outputs upd_* and mispredict are single-cycle pulses. upd_* hold their last value when upd_valid=0. redirect_pc holds its last value.
- Counters: br_commits increments on each control commit; br_mispredicts increments on each mispredict; both wrap at 2**32.
- Reset asserted mid-operation: immediate clear of the queue and all pulses; no pending pulse survives reset.

Decomposition:
- rv32im_types supplies op_b_br/op_b_jal/op_b_jalr and adds a pred_entry_t struct (pc, pred_next, pred_take).
- One sub-module: br_pred_fifo (parametric circular buffer with flush, push/pop, count). Compare, update and counter logic stay in the top.

Test Plan:
- Reset then release: q_count=0, redirect_pc=32'h1eceb000, enq_ready=1 the cycle after release, mispredict=0.
- Push {pc=0x1000, next=0x1040, take=1}; commit op_b_br pc=0x1000 next=0x1040 -> next cycle upd_valid=1, upd_take=1, upd_target=0x1040, mispredict=0, q_count=0.
- Push {0x2000, 0x2004, 0}; commit op_b_br pc=0x2000 next=0x2080 -> mispredict=1, redirect_pc=0x2080, queue flushed, br_mispredicts=1.
- Fill 8 entries -> enq_ready=0; commit 8 matching branches while pushing 8 more -> correct wrap, q_count tracks exactly, no mispredict.
- Commit op_b_jalr pc=0x3000 next=0x3100 with empty queue -> mispredict=1, redirect_pc=0x3100, upd_take=1, upd_opcode=op_b_jalr.
- Non-control commit (opcode 7'b0110011) with 2 entries queued -> no upd_valid, q_count stays 2, counters unchanged.

Source files
------------

// File: rtl/rv32im_types.sv
// Shared RV32IM opcode constants and the branch prediction record queued by fetch.
package rv32im_types;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned XLEN     = 32;

  localparam logic [OPCODE_W-1:0] op_b_br   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] op_b_jal  = 7'b1101111;
  localparam logic [OPCODE_W-1:0] op_b_jalr = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_next;
    logic            pred_take;
  } pred_entry_t;

  function automatic logic is_control_op(input logic [OPCODE_W-1:0] op);
    return (op == op_b_br) || (op == op_b_jal) || (op == op_b_jalr);
  endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// Circular buffer of prediction records with push, pop, flush and occupancy count.
module br_pred_fifo
  import rv32im_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  pred_entry_t           push_data,
  input  logic                  pop,
  output pred_entry_t           head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  pred_entry_t         mem [ENTRIES];
  logic                do_push;
  logic                do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (DEPTH_LOG2+1)'(ENTRIES));
  assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign do_pop  = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/br_resolve_queue.sv
// Commit-side branch resolution: checks retiring control ops against fetch
// predictions, trains the BTB and raises a redirect with queue flush on mispredict.
module br_resolve_queue
  import rv32im_types::*;
#(
  parameter int unsigned QUEUE_DEPTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [31:0]            enq_pc,
  input  logic [31:0]            enq_pred_next,
  input  logic                   enq_pred_take,
  input  logic                   rob_commit,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_pc_next,
  input  logic [6:0]             commit_opcode,
  output logic                   upd_valid,
  output logic                   upd_take,
  output logic [31:0]            upd_pc,
  output logic [31:0]            upd_target,
  output logic [6:0]             upd_opcode,
  output logic                   mispredict,
  output logic [31:0]            redirect_pc,
  output logic [QUEUE_DEPTH:0]   q_count,
  output logic [31:0]            br_commits,
  output logic [31:0]            br_mispredicts
);

  pred_entry_t head;
  pred_entry_t push_data;
  logic        full;
  logic        empty;
  logic        ctrl_c;
  logic        actual_take_c;
  logic        match_c;
  logic        mis_c;
  logic        pop_c;
  logic        push_c;

  // Head comparison against the architectural outcome of the retiring op.
  assign ctrl_c        = rob_commit && is_control_op(commit_opcode);
  assign actual_take_c = (commit_opcode == op_b_br) ? (commit_pc_next != commit_pc + 32'd4) : 1'b1;
  assign match_c       = !empty && (head.pc == commit_pc) && (head.pred_next == commit_pc_next)
                         && (head.pred_take == actual_take_c);
  assign mis_c         = ctrl_c && !match_c;
  assign pop_c         = ctrl_c && match_c;

  assign enq_ready = rst && !full && !mispredict;
  assign push_c    = enq_valid && enq_ready;
  assign push_data = '{pc: enq_pc, pred_next: enq_pred_next, pred_take: enq_pred_take};

  br_pred_fifo #(.DEPTH_LOG2(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (mis_c),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .head      (head),
    .count     (q_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid      <= 1'b0;
      upd_take       <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      upd_opcode     <= '0;
      mispredict     <= 1'b0;
      redirect_pc    <= RESET_PC;
      br_commits     <= '0;
      br_mispredicts <= '0;
    end else begin
      upd_valid  <= ctrl_c;
      mispredict <= mis_c;
      if (ctrl_c) begin
        upd_take   <= actual_take_c;
        upd_pc     <= commit_pc;
        upd_target <= commit_pc_next;
        upd_opcode <= commit_opcode;
        br_commits <= br_commits + 32'd1;
      end
      if (mis_c) begin
        redirect_pc    <= commit_pc_next;
        br_mispredicts <= br_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Randomized and directed bench for br_resolve_queue against a queue-based reference model.
module tb_br_resolve_queue;
  import rv32im_types::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;
  localparam logic [6:0]  OP_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_pred_next = '0;
  logic        enq_pred_take = 1'b0;
  logic        rob_commit = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_pc_next = '0;
  logic [6:0]  commit_opcode = OP_ADD;
  logic        upd_valid;
  logic        upd_take;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [6:0]  upd_opcode;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  q_count;
  logic [31:0] br_commits;
  logic [31:0] br_mispredicts;

  br_resolve_queue dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred_next(enq_pred_next), .enq_pred_take(enq_pred_take),
    .rob_commit(rob_commit), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
    .commit_opcode(commit_opcode),
    .upd_valid(upd_valid), .upd_take(upd_take), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_opcode(upd_opcode), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .q_count(q_count), .br_commits(br_commits), .br_mispredicts(br_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nx;
    logic        tk;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic        m_mis;
  logic        m_upd_valid, m_upd_take;
  logic [31:0] m_upd_pc, m_upd_target, m_redirect, m_commits, m_mispreds;
  logic [6:0]  m_upd_op;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mis = 0; m_upd_valid = 0; m_upd_take = 0;
    m_upd_pc = '0; m_upd_target = '0; m_upd_op = '0;
    m_redirect = RST_PC; m_commits = '0; m_mispreds = '0;
  endtask

  task automatic check_regs();
    chk("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
    chk("upd_take", 32'(upd_take), 32'(m_upd_take));
    chk("upd_pc", upd_pc, m_upd_pc);
    chk("upd_target", upd_target, m_upd_target);
    chk("upd_opcode", 32'(upd_opcode), 32'(m_upd_op));
    chk("mispredict", 32'(mispredict), 32'(m_mis));
    chk("redirect_pc", redirect_pc, m_redirect);
    chk("br_commits", br_commits, m_commits);
    chk("br_mispredicts", br_mispredicts, m_mispreds);
  endtask

  task automatic drive(input logic ev, input logic [31:0] epc, input logic [31:0] enx,
                       input logic etk, input logic rc, input logic [31:0] cpc,
                       input logic [31:0] cnx, input logic [6:0] op);
    enq_valid = ev; enq_pc = epc; enq_pred_next = enx; enq_pred_take = etk;
    rob_commit = rc; commit_pc = cpc; commit_pc_next = cnx; commit_opcode = op;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, 0, '0, '0, OP_ADD);
  endtask

  // One clock: check combinational view, advance the model from the spec rules, check registers.
  task automatic step();
    logic ctrl, take, hit, accept;
    ent_t e;
    #1;
    chk("enq_ready", 32'(enq_ready), 32'(mq.size() < 8 && !m_mis));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    ctrl = rob_commit && (commit_opcode == op_b_br || commit_opcode == op_b_jal ||
                          commit_opcode == op_b_jalr);
    take = (commit_opcode == op_b_br) ? (commit_pc_next != commit_pc + 32'd4) : 1'b1;
    hit  = ctrl && mq.size() > 0 && mq[0].pc == commit_pc && mq[0].nx == commit_pc_next
           && mq[0].tk == take;
    accept = enq_valid && mq.size() < 8 && !m_mis;
    e.pc = enq_pc; e.nx = enq_pred_next; e.tk = enq_pred_take;
    @(posedge clk);
    #1;
    m_upd_valid = ctrl;
    m_mis = ctrl && !hit;
    if (ctrl) begin
      m_commits++;
      m_upd_take = take; m_upd_pc = commit_pc; m_upd_target = commit_pc_next;
      m_upd_op = commit_opcode;
    end
    if (m_mis) begin
      mq.delete();
      m_mispreds++;
      m_redirect = commit_pc_next;
    end else begin
      if (hit) void'(mq.pop_front());
      if (accept) mq.push_back(e);
    end
    check_regs();
  endtask

  function automatic ent_t rand_entry();
    ent_t e;
    e.pc = {$urandom() & 32'hffff_fffc};
    e.tk = 1'($urandom_range(0, 1));
    e.nx = e.tk ? e.pc + 32'd8 + (32'($urandom_range(0, 1023)) << 2) : e.pc + 32'd4;
    return e;
  endfunction

  initial begin
    ent_t e;
    logic [6:0] op;
    int r;
    model_reset();
    idle();
    #23;
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_redirect", redirect_pc, RST_PC);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Matching taken branch
    drive(1, 32'h1000, 32'h1040, 1, 0, '0, '0, OP_ADD); step();
    drive(0, '0, '0, 0, 1, 32'h1000, 32'h1040, op_b_br); step();
    chk("match_q_count", 32'(q_count), 32'd0);

    // Not-taken prediction resolved taken -> mispredict and flush
    drive(1, 32'h2000, 32'h2004, 0, 0, '0, '0, OP_ADD); step();
    drive(0, '0, '0, 0, 1, 32'h2000, 32'h2080, op_b_br); step();
    chk("misp_redirect", redirect_pc, 32'h2080);
    idle(); step();

    // Fill queue, then drain with matches while pushing more
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h4000 + 32'(i * 16), 32'h4000 + 32'(i * 16) + 32'd4, 0, 0, '0, '0, OP_ADD);
      step();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 32'h5000 + 32'(i * 16), 32'h5000 + 32'(i * 16) + 32'd4, 0,
            1, 32'h4000 + 32'(i * 16), 32'h4000 + 32'(i * 16) + 32'd4, op_b_br);
      if (i == 8) begin
        commit_pc = 32'h5010; commit_pc_next = 32'h5014;
      end
      step();
    end
    while (mq.size() > 0) begin
      drive(0, '0, '0, 0, 1, mq[0].pc, mq[0].nx, op_b_br); step();
    end

    // JALR with empty queue
    drive(0, '0, '0, 0, 1, 32'h3000, 32'h3100, op_b_jalr); step();
    chk("jalr_redirect", redirect_pc, 32'h3100);
    idle(); step();

    // Non-control commit with two queued entries
    drive(1, 32'h6000, 32'h6004, 0, 0, '0, '0, OP_ADD); step();
    drive(1, 32'h6010, 32'h6100, 1, 0, '0, '0, OP_ADD); step();
    drive(0, '0, '0, 0, 1, 32'h6000, 32'h6004, OP_ADD); step();
    chk("nonctl_q_count", 32'(q_count), 32'd2);

    // Randomized traffic with one mid-stream reset
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0) begin
        e = rand_entry();
        enq_valid = 1; enq_pc = e.pc; enq_pred_next = e.nx; enq_pred_take = e.tk;
      end
      r = $urandom_range(0, 9);
      if (r < 5 && mq.size() > 0) begin
        op = !mq[0].tk ? op_b_br : (r[0] ? op_b_br : (r[1] ? op_b_jal : op_b_jalr));
        rob_commit = 1; commit_pc = mq[0].pc; commit_pc_next = mq[0].nx; commit_opcode = op;
      end else if (r == 5) begin
        e = rand_entry();
        rob_commit = 1; commit_pc = e.pc; commit_pc_next = e.nx;
        commit_opcode = r[0] ? op_b_jal : op_b_br;
      end else if (r == 6) begin
        rob_commit = 1; commit_pc = $urandom(); commit_pc_next = $urandom();
        commit_opcode = OP_ADD;
      end
      step();
      if (c == 400) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_q_count", 32'(q_count), 32'd0);
        chk("midrst_enq_ready", 32'(enq_ready), 32'd0);
        check_regs();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
